// File: rtl/seq_right_shifter.sv
// Multi-cycle right shifter: loads an operand on Start and shifts it one bit
// per clock, logical or arithmetic. It pulses Done with a registered result.
module seq_right_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Start,
    input  logic               Arith,
    input  logic [WIDTH-1:0]   ValueIn,
    input  logic [SHAMT_W-1:0] Shamt,
    output logic               Busy,
    output logic               Done,
    output logic [WIDTH-1:0]   ValueOut
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W-1:0] r_count;
    logic               r_fill;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_value_out;

    logic [WIDTH-1:0]   w_shifted;

    // The fill bit is the captured sign, so it stays constant for the whole shift.
    assign w_shifted = {r_fill, r_work[WIDTH-1:1]};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= ST_IDLE;
            r_work      <= '0;
            r_count     <= '0;
            r_fill      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_value_out <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (Start) begin
                        r_work  <= ValueIn;
                        r_count <= Shamt;
                        r_fill  <= Arith & ValueIn[WIDTH-1];
                        if (Shamt == '0) begin
                            r_value_out <= ValueIn;
                            r_done      <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= ST_DONE;
                        end else begin
                            r_done  <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= ST_SHIFT;
                        end
                    end else begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    r_work  <= w_shifted;
                    r_count <= r_count - SHAMT_W'(1);
                    if (r_count == SHAMT_W'(1)) begin
                        r_value_out <= w_shifted;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_DONE;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Busy     = r_busy;
    assign Done     = r_done;
    assign ValueOut = r_value_out;

endmodule

// File: tb/tb_seq_right_shifter.sv
// Bench for seq_right_shifter: directed cases followed by random operations.
// The cases are checked cycle by cycle against an arithmetic reference model.
module tb_seq_right_shifter;

    logic        Clk;
    logic        Reset_n;
    logic        Start;
    logic        Arith;
    logic [31:0] ValueIn;
    logic [4:0]  Shamt;
    logic        Busy;
    logic        Done;
    logic [31:0] ValueOut;

    int          n_vec;
    int          n_err;
    logic [31:0] exp_out;

    seq_right_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Start    (Start),
        .Arith    (Arith),
        .ValueIn  (ValueIn),
        .Shamt    (Shamt),
        .Busy     (Busy),
        .Done     (Done),
        .ValueOut (ValueOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] ref_shift(input logic [31:0] v, input int s, input logic a);
        if (a)
            return 32'($signed(v) >>> s);
        return v >> s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Call just after a falling edge. On return the bench is at the falling
    // edge of the DONE cycle, with Start low.
    task automatic op(input logic [31:0] v, input int s, input logic a, input int glitch);
        logic [31:0] res;
        res     = ref_shift(v, s, a);
        ValueIn = v;
        Shamt   = 5'(s);
        Arith   = a;
        Start   = 1'b1;
        @(posedge Clk);
        for (int k = 0; k <= s; k++) begin
            @(negedge Clk);
            Start = (k == glitch && k < s) ? 1'b1 : 1'b0;
            if (k == glitch) begin
                ValueIn = 32'h0000_0001;
                Shamt   = 5'd1;
                Arith   = 1'b0;
            end else begin
                ValueIn = $urandom;
                Shamt   = 5'($urandom_range(0, 31));
                Arith   = 1'($urandom_range(0, 1));
            end
            if (k < s) begin
                check("busy_in_shift", 32'(Busy), 32'd1);
                check("done_in_shift", 32'(Done), 32'd0);
                check("hold_in_shift", ValueOut, exp_out);
            end else begin
                exp_out = res;
                check("done_pulse", 32'(Done), 32'd1);
                check("busy_at_done", 32'(Busy), 32'd0);
                check("result", ValueOut, exp_out);
            end
        end
        $display("op v=%h shamt=%0d arith=%0d -> out=%h exp=%h", v, s, a, ValueOut, res);
    endtask

    task automatic idle_cycle();
        Start = 1'b0;
        @(negedge Clk);
        check("idle_done", 32'(Done), 32'd0);
        check("idle_busy", 32'(Busy), 32'd0);
        check("idle_hold", ValueOut, exp_out);
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        exp_out = 32'h0;
        Reset_n = 1'b0;
        Start   = 1'b0;
        Arith   = 1'b0;
        ValueIn = 32'h0;
        Shamt   = 5'd0;
        #1;
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_done", 32'(Done), 32'd0);
        check("reset_out", ValueOut, 32'h0);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        idle_cycle();

        // Directed cases from the test plan
        op(32'hF000_0000, 4, 1'b0, -1);
        idle_cycle();
        op(32'h8000_0000, 31, 1'b1, -1);
        idle_cycle();
        op(32'h8000_0000, 31, 1'b0, -1);
        idle_cycle();
        op(32'h1234_5678, 0, 1'b0, -1);
        idle_cycle();
        op(32'h7FFF_FFFF, 1, 1'b1, -1);
        idle_cycle();
        op(32'hFFFF_0000, 8, 1'b0, 2);
        for (int i = 0; i < 4; i++)
            idle_cycle();
        // Back-to-back: the second start is presented during the first DONE cycle
        op(32'h0000_00F0, 3, 1'b0, -1);
        op(32'h8000_0010, 4, 1'b1, -1);
        idle_cycle();

        // Asynchronous reset in the middle of a 20-bit shift
        ValueIn = 32'hDEAD_BEEF;
        Shamt   = 5'd20;
        Arith   = 1'b1;
        Start   = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        exp_out = 32'h0;
        check("midrst_busy", 32'(Busy), 32'd0);
        check("midrst_done", 32'(Done), 32'd0);
        check("midrst_out", ValueOut, 32'h0);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        idle_cycle();
        idle_cycle();
        op(32'hA5A5_A5A5, 1, 1'b1, -1);
        idle_cycle();

        // Random operations, with back-to-back starts mixed with idle gaps
        for (int n = 0; n < 40; n++) begin
            op($urandom, int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1);
            if ($urandom_range(0, 1) == 1)
                idle_cycle();
        end
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
